// File: rtl/clkcfg_sequencer.sv
// Sequences Propeller clock-mode changes into the clock generator: enables apply at once,
// CLKSEL follows after a settle interval, and cfg[7] becomes a stretched reset request.
module clkcfg_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16000,
  parameter int unsigned RESET_CYCLES  = 16
) (
  input  logic       clock_160,
  input  logic       nres,
  input  logic [7:0] cfg_in,
  output logic [6:0] cfg_out,
  output logic       reset_req,
  output logic       busy
);

  localparam int unsigned MAX_CYCLES = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CFG_W      = 8;
  localparam int unsigned OUT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SETTLE     = 2'd1,
    ST_RESET_HOLD = 2'd2
  } state_e;

  logic [CFG_W-1:0] s1_q, s2_q, s3_q, cfg_req_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] cfg_out_q, cfg_out_d;
  logic             reset_req_q, reset_req_d;
  logic             busy_q, busy_d;
  logic [1:0]       new_en;

  // Two-flop synchronizer plus a compare stage so only a value seen twice is accepted.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      cfg_req_q <= '0;
    end else begin
      s1_q <= cfg_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (s2_q == s3_q) begin
        cfg_req_q <= s2_q;
      end
    end
  end

  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_out_q   <= '0;
      reset_req_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_out_q   <= cfg_out_d;
      reset_req_q <= reset_req_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_out_d   = cfg_out_q;
    reset_req_d = reset_req_q;
    new_en      = cfg_req_q[6:5] & ~cfg_out_q[6:5];

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_req_q[7]) begin
          cfg_out_d   = '0;
          reset_req_d = 1'b1;
          cnt_d       = CNT_W'(RESET_CYCLES - 1);
          state_d     = ST_RESET_HOLD;
        end else if (new_en != 2'b00) begin
          // A newly enabled source: apply enables/OSCM now, keep the old CLKSEL.
          cfg_out_d[6:3] = cfg_req_q[6:3];
          cnt_d          = CNT_W'(SETTLE_CYCLES - 1);
          state_d        = ST_SETTLE;
        end else if (cfg_req_q[6:0] != cfg_out_q) begin
          cfg_out_d = cfg_req_q[6:0];
        end
      end

      ST_SETTLE: begin
        if (cfg_req_q[7]) begin
          cfg_out_d   = '0;
          reset_req_d = 1'b1;
          cnt_d       = CNT_W'(RESET_CYCLES - 1);
          state_d     = ST_RESET_HOLD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Only commit CLKSEL if the enables it was settled against are still requested.
          if (cfg_req_q[6:3] == cfg_out_q[6:3]) begin
            cfg_out_d[2:0] = cfg_req_q[2:0];
          end
          state_d = ST_IDLE;
        end
      end

      ST_RESET_HOLD: begin
        cfg_out_d   = '0;
        reset_req_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!cfg_req_q[7]) begin
          reset_req_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign cfg_out   = cfg_out_q;
  assign reset_req = reset_req_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clkcfg_sequencer.sv
// Bench for clkcfg_sequencer: directed scenarios plus randomized cfg_in traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_clkcfg_sequencer;

  localparam int unsigned SETTLE = 8;
  localparam int unsigned RESET  = 4;

  logic       clk = 1'b0;
  logic       nres;
  logic [7:0] cfg_in;
  logic [6:0] cfg_out;
  logic       reset_req;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  clkcfg_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .RESET_CYCLES (RESET)
  ) dut (
    .clock_160(clk),
    .nres     (nres),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .reset_req(reset_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus the edge index at which the mode was entered.
  typedef enum {M_IDLE, M_SETTLE, M_RESET} mode_e;
  mode_e      m_mode;
  logic [7:0] m_req;
  logic [6:0] m_out;
  logic       m_rr;
  int         m_edge;
  int         m_start;
  logic [7:0] samp [3];  // last three cfg_in samples, oldest first

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_req  = 8'h00;
    m_out  = 7'h00;
    m_rr   = 1'b0;
    m_edge = 0;
    for (int i = 0; i < 3; i++) samp[i] = 8'h00;
  endtask

  task automatic model_enter_reset();
    m_out   = 7'h00;
    m_rr    = 1'b1;
    m_mode  = M_RESET;
    m_start = m_edge;
  endtask

  // Advance the model by one clock edge using the pre-edge accepted request.
  task automatic model_edge(input logic [7:0] din);
    logic [1:0] fresh;
    m_edge++;
    fresh = m_req[6:5] & ~m_out[6:5];
    case (m_mode)
      M_IDLE: begin
        if (m_req[7]) model_enter_reset();
        else if (fresh != 2'b00) begin
          m_out[6:3] = m_req[6:3];
          m_mode     = M_SETTLE;
          m_start    = m_edge;
        end else m_out = m_req[6:0];
      end
      M_SETTLE: begin
        if (m_req[7]) model_enter_reset();
        else if (m_edge - m_start >= int'(SETTLE)) begin
          if (m_req[6:3] == m_out[6:3]) m_out[2:0] = m_req[2:0];
          m_mode = M_IDLE;
        end
      end
      default: begin
        m_out = 7'h00;
        if ((m_edge - m_start >= int'(RESET)) && !m_req[7]) begin
          m_rr   = 1'b0;
          m_mode = M_IDLE;
        end
      end
    endcase
    // A value is accepted once two consecutive synchronized samples agree.
    if (samp[1] == samp[0]) m_req = samp[1];
    samp[0] = samp[1];
    samp[1] = samp[2];
    samp[2] = din;
  endtask

  task automatic compare_model();
    check_eq("cfg_out", 32'(cfg_out), 32'(m_out));
    check_eq("reset_req", 32'(reset_req), 32'(m_rr));
    check_eq("busy", 32'(busy), 32'(m_mode != M_IDLE));
  endtask

  task automatic tick();
    logic [7:0] din;
    @(posedge clk);
    din = cfg_in;
    if (nres) model_edge(din);
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse launched between edges; outputs must clear at once.
  task automatic abort_pulse();
    nres = 1'b0;
    #1;
    model_reset();
    check_eq("abort_out", 32'(cfg_out), 32'h0);
    check_eq("abort_rr", 32'(reset_req), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'h0);
    ticks(2);
    nres = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    bit fell;
    bit seen;
    logic [7:0] v;

    model_reset();
    nres   = 1'b0;
    cfg_in = 8'hFF;
    ticks(4);
    check_eq("rst_out", 32'(cfg_out), 32'h0);
    check_eq("rst_rr", 32'(reset_req), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    cfg_in = 8'h00;
    nres   = 1'b1;
    ticks(6);

    // CLKSEL-only change
    cfg_in = 8'h01;
    ticks(4);
    check_eq("sel_early", 32'(cfg_out), 32'h00);
    tick();
    check_eq("sel_out", 32'(cfg_out), 32'h01);
    check_eq("sel_busy", 32'(busy), 32'h0);
    cfg_in = 8'h00;
    ticks(7);

    // PLL+OSC enable with settle
    cfg_in = 8'h6F;
    ticks(5);
    check_eq("en_out", 32'(cfg_out), 32'h68);
    check_eq("en_busy", 32'(busy), 32'h1);
    ticks(SETTLE - 1);
    check_eq("settle_hold", 32'(cfg_out), 32'h68);
    tick();
    check_eq("settle_out", 32'(cfg_out), 32'h6F);
    check_eq("settle_busy", 32'(busy), 32'h0);
    ticks(3);

    // Disable: immediate, no SETTLE
    cfg_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("dis_busy", 32'(busy), 32'h0);
    end
    check_eq("dis_out", 32'(cfg_out), 32'h00);
    ticks(3);

    // Software reset arriving three cycles into SETTLE
    cfg_in = 8'h6F;
    ticks(8);
    cfg_in = 8'hEF;
    seen   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (reset_req) seen = 1'b1;
    end
    check_eq("swrst_seen", 32'(seen), 32'h1);
    check_eq("swrst_out", 32'(cfg_out), 32'h00);
    hi_cnt = 1;
    ticks(5);
    hi_cnt += 5;
    cfg_in = 8'h00;
    fell   = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      tick();
      if (reset_req) hi_cnt++;
      else fell = 1'b1;
    end
    check_eq("swrst_fell", 32'(fell), 32'h1);
    check_eq("swrst_len_ok", 32'(hi_cnt >= int'(RESET)), 32'h1);
    ticks(3);

    // nres mid-SETTLE
    cfg_in = 8'h6F;
    ticks(8);
    check_eq("pre_abort_busy", 32'(busy), 32'h1);
    abort_pulse();
    check_eq("post_abort_sel", 32'(cfg_out[2:0] == 3'd7), 32'h0);
    cfg_in = 8'h00;
    ticks(8);

    // Glitching input must never be accepted
    for (int i = 0; i < 20; i++) begin
      cfg_in = (i % 2 == 1) ? 8'h07 : 8'h00;
      tick();
      check_eq("glitch_out", 32'(cfg_out), 32'h00);
    end
    ticks(3);
    check_eq("glitch_late", 32'(cfg_out), 32'h00);
    tick();
    check_eq("glitch_final", 32'(cfg_out), 32'h07);

    // Randomized traffic against the model
    for (int seg = 0; seg < 300; seg++) begin
      v    = 8'($urandom);
      v[7] = ($urandom_range(0, 7) == 0);
      cfg_in = v;
      if ($urandom_range(0, 39) == 0) abort_pulse();
      ticks(int'($urandom_range(1, SETTLE + 8)));
    end
    cfg_in = 8'h00;
    ticks(SETTLE + RESET + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkcfg_sequencer.md
# clkcfg_sequencer

Sequences Propeller clock-mode changes between the core's `cfg` register output and the Xilinx clock generator's `cfg` input. Oscillator/PLL enables are applied at once; the matching CLKSEL switch is held back until a settle interval has elapsed. A cfg[7] software-reset request becomes a stretched, clean reset request. The block runs on the free-running `clock_160`, so it keeps working while CLKSEL changes the cog clock.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16000: `clock_160` cycles between enabling OSC/PLL and switching CLKSEL (100 µs); minimum 1.
- `RESET_CYCLES`, default 16: minimum `reset_req` assertion length; minimum 1.
- Counter width: `$clog2(max(SETTLE_CYCLES, RESET_CYCLES)+1)`.

Ports:
- `clock_160`  in  1  free-running 160 MHz clock, sole clock.
- `nres`  in  1  asynchronous, active-low reset.
- `cfg_in`  in  8  core cfg (CLK register), asynchronous to `clock_160`: [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
- `cfg_out`  out  7  to clock generator `cfg[6:0]`.
- `reset_req`  out  1  stretched software-reset request, combined into the core reset.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Input capture:
  - `cfg_in` passes through two sync flops (s1, s2), then a compare flop s3.
  - `cfg_req` is loaded from s2 only when s2 == s3. Multi-bit skew or glitches never produce a mixed value.
- States: IDLE, SETTLE, RESET_HOLD. One down-counter `cnt` is shared by SETTLE and RESET_HOLD.
- IDLE, evaluated in this priority order:
  1. `cfg_req[7]`=1: `cfg_out` ← 0, `reset_req` ← 1, `cnt` ← RESET_CYCLES-1, go to RESET_HOLD.
  2. Else, if `cfg_req[6:5] & ~cfg_out[6:5]` ≠ 0 (a newly enabled source): `cfg_out[6:3]` ← `cfg_req[6:3]`; `cfg_out[2:0]` unchanged; `cnt` ← SETTLE_CYCLES-1; go to SETTLE.
  3. Else, if `cfg_req[6:0]` ≠ `cfg_out`: `cfg_out` ← `cfg_req[6:0]` in one cycle. This covers disables, OSCM changes and CLKSEL-only changes.
- SETTLE:
  - `cfg_req[7]`=1 takes priority: same action as IDLE item 1, entered immediately.
  - Else, while `cnt` ≠ 0: decrement `cnt`.
  - Else (`cnt` = 0), if `cfg_req[6:3]` == `cfg_out[6:3]`: `cfg_out[2:0]` ← `cfg_req[2:0]`, go to IDLE.
  - Else (`cnt` = 0, enables changed during settle): `cfg_out[2:0]` stays unchanged, go to IDLE. IDLE re-evaluates on the next cycle.
- RESET_HOLD:
  - `reset_req`=1 and `cfg_out`=0 throughout.
  - Decrement `cnt` to 0.
  - At `cnt`=0, wait until `cfg_req[7]`=0, then `reset_req` ← 0 and go to IDLE.
- `cfg_out` never selects a source in the same cycle that source is enabled, except a disable-then-select written by the core. Sequencing that case is the core's responsibility and is passed through unchanged.

## Timing
- `nres` low, asynchronously: state IDLE; `cfg_out`=7'h00, `reset_req`=0, `busy`=0; s1, s2, s3, `cfg_req` and `cnt` = 0.
- A stable `cfg_in` change at edge 0 reaches `cfg_req` after edge 4.
- Immediate updates appear on `cfg_out` after edge 5.
- Settle path:
  - Enable bits update after edge 5; `busy` is high from edge 5.
  - CLKSEL updates, and `busy` falls, after edge 5+SETTLE_CYCLES.
- Reset path: `reset_req` and `busy` rise after edge 5. `reset_req` stays high for at least RESET_CYCLES cycles and until `cfg_req[7]` has been observed 0.
- `nres` asserted mid-SETTLE or mid-RESET_HOLD aborts immediately to reset values. No partial CLKSEL update is retained.

## Test plan
Bench overrides: SETTLE_CYCLES=8, RESET_CYCLES=4.
- Reset: `nres` low with `cfg_in`=0xFF → `cfg_out`=0x00, `reset_req`=0, `busy`=0, held while low.
- CLKSEL-only: `cfg_in` 0x00→0x01 → `cfg_out`=0x01 five cycles later; `busy` stays 0.
- PLL+OSC enable: `cfg_in` 0x00→0x6F → `cfg_out`=0x68 and `busy`=1 after 5 cycles → `cfg_out`=0x6F and `busy`=0 exactly 8 cycles later.
- Reset during settle: `cfg_in` 0x6F, then 0xEF three cycles into SETTLE → `reset_req`=1 and `cfg_out`=0x00 within 5 cycles. Hold 0xEF for 10 cycles, then 0x00 → `reset_req` falls after the sync latency; total high time ≥ 4.
- Disable and abort: from settled 0x6F, `cfg_in`=0x00 → `cfg_out`=0x00 after 5 cycles, no SETTLE entered. Separately, `nres` pulsed low mid-SETTLE → all outputs 0 immediately, and `cfg_out[2:0]` never shows 7.
- Glitch: `cfg_in` toggling 0x00/0x07 every cycle for 20 cycles → `cfg_out` unchanged. Stable 0x07 afterwards → `cfg_out`=0x07 five cycles after the last toggle.
